// File: rtl/vga_timing_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_fsm
//  Purpose  : 640x480@60 Hz VGA raster timing generator. Divides the system
//             clock down to a pixel enable and runs horizontal/vertical pixel
//             counters. Visible coordinates, the framebuffer read enable,
//             blanking flags and the sync pulses are decoded from those
//             counters. This block has no data path.
//  Ports    : clk    - system clock
//             rst    - synchronous, active-high reset (restarts frame at 0,0)
//             row    - visible line index 0..V_VISIBLE-1, 0 when blanked
//             col    - visible pixel index 0..H_VISIBLE-1, 0 when blanked
//             Hsync  - horizontal sync (active low by default)
//             Vsync  - vertical sync (active low by default)
//             en_r   - high while (col,row) is a visible pixel
//             hBlank - high while hcnt >= H_VISIBLE
//             vBlank - high while vcnt >= V_VISIBLE
//  Options  : VGA_SYNC_POSITIVE_EN - when defined, Hsync and Vsync are
//             active high (idle and reset value 0).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_fsm #(
    parameter int CLK_PER_PIX = 2,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [8:0] row,
    output logic [9:0] col,
    output logic       Hsync,
    output logic       Vsync,
    output logic       en_r,
    output logic       hBlank,
    output logic       vBlank
);

    localparam int c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counter widths; each kept at least 1 bit so degenerate settings
    // (e.g. CLK_PER_PIX = 1) still elaborate.
    localparam int c_DIV_W    = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam int c_H_W      = (c_H_TOTAL > 1) ? $clog2(c_H_TOTAL) : 1;
    localparam int c_V_W      = (c_V_TOTAL > 1) ? $clog2(c_V_TOTAL) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_PER_PIX - 1);
    localparam logic [c_H_W-1:0]   c_H_LAST   = c_H_W'(c_H_TOTAL - 1);
    localparam logic [c_V_W-1:0]   c_V_LAST   = c_V_W'(c_V_TOTAL - 1);

    // Sync windows, half-open [START, END). Kept 32 bits wide so an END equal
    // to the total count cannot wrap in a narrow counter width.
    localparam logic [31:0] c_H_VIS      = 32'(H_VISIBLE);
    localparam logic [31:0] c_V_VIS      = 32'(V_VISIBLE);
    localparam logic [31:0] c_HS_START   = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] c_HS_END     = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] c_VS_START   = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] c_VS_END     = 32'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [c_DIV_W-1:0] r_div;
    logic [c_H_W-1:0]   r_hcnt;
    logic [c_V_W-1:0]   r_vcnt;

    logic               w_pix_en;
    logic [31:0]        w_h32;
    logic [31:0]        w_v32;
    logic               w_hblank;
    logic               w_vblank;
    logic               w_visible;
    logic               w_hsync_act;
    logic               w_vsync_act;

    // With CLK_PER_PIX = 1 the divider is pinned at 0 and this is always high.
    assign w_pix_en = (r_div == c_DIV_LAST);

    // ------------------------------------------------------------------
    // Pixel divider and raster counters. Reset wins over pix_en.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
            if (r_hcnt == c_H_LAST) begin
                r_hcnt <= '0;
                if (r_vcnt == c_V_LAST) begin
                    r_vcnt <= '0;
                end else begin
                    r_vcnt <= r_vcnt + c_V_W'(1);
                end
            end else begin
                r_hcnt <= r_hcnt + c_H_W'(1);
            end
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output decode: purely combinational from the counters so outputs move
    // on the same edge as hcnt/vcnt.
    // ------------------------------------------------------------------
    assign w_h32       = 32'(r_hcnt);
    assign w_v32       = 32'(r_vcnt);

    assign w_hblank    = (w_h32 >= c_H_VIS);
    assign w_vblank    = (w_v32 >= c_V_VIS);
    assign w_visible   = !w_hblank && !w_vblank;

    assign w_hsync_act = (w_h32 >= c_HS_START) && (w_h32 < c_HS_END);
    assign w_vsync_act = (w_v32 >= c_VS_START) && (w_v32 < c_VS_END);

    assign hBlank = w_hblank;
    assign vBlank = w_vblank;
    assign en_r   = w_visible;
    assign col    = w_visible ? w_h32[9:0] : 10'd0;
    assign row    = w_visible ? w_v32[8:0] : 9'd0;

`ifdef VGA_SYNC_POSITIVE_EN
    assign Hsync  = w_hsync_act;
    assign Vsync  = w_vsync_act;
`else
    assign Hsync  = ~w_hsync_act;
    assign Vsync  = ~w_vsync_act;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_fsm
//  Purpose  : Self-checking bench for vga_timing_fsm. Instance A uses the
//             default 640x480 timing with CLK_PER_PIX = 2; instance B uses a
//             tiny raster (15 x 10 pixels, CLK_PER_PIX = 1) so full-frame
//             vertical behaviour fits in a short run. Sync polarity follows
//             VGA_SYNC_POSITIVE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_fsm;

`ifdef VGA_SYNC_POSITIVE_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;

    logic [8:0] row_a, row_b;
    logic [9:0] col_a, col_b;
    logic       hs_a, vs_a, en_a, hb_a, vb_a;
    logic       hs_b, vs_b, en_b, hb_b, vb_b;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    always #5 clk = ~clk;

    vga_timing_fsm dut_a (
        .clk    (clk),
        .rst    (rst_a),
        .row    (row_a),
        .col    (col_a),
        .Hsync  (hs_a),
        .Vsync  (vs_a),
        .en_r   (en_a),
        .hBlank (hb_a),
        .vBlank (vb_a)
    );

    // Small raster: H 8+2+3+2 = 15 (sync at 10..12), V 6+1+2+1 = 10 (sync at 7..8).
    vga_timing_fsm #(
        .CLK_PER_PIX (1),
        .H_VISIBLE   (8),
        .H_FRONT     (2),
        .H_SYNC      (3),
        .H_BACK      (2),
        .V_VISIBLE   (6),
        .V_FRONT     (1),
        .V_SYNC      (2),
        .V_BACK      (1)
    ) dut_b (
        .clk    (clk),
        .rst    (rst_b),
        .row    (row_b),
        .col    (col_b),
        .Hsync  (hs_b),
        .Vsync  (vs_b),
        .en_r   (en_b),
        .hBlank (hb_b),
        .vBlank (vb_b)
    );

    typedef struct {
        int cyc;   // clocks since reset release
        bit sel;   // 0 = instance A, 1 = instance B
        int row;
        int col;
        bit en;
        bit hb;
        bit vb;
        bit hs;    // 1 = sync pulse active
        bit vs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int cyc, input bit sel, input int r, input int c,
                       input bit en, input bit hb, input bit vb,
                       input bit hs, input bit vs);
        vec_t v;
        v.cyc = cyc; v.sel = sel; v.row = r; v.col = c;
        v.en = en; v.hb = hb; v.vb = vb; v.hs = hs; v.vs = vs;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cur, act, exp);
        end
    endtask

    function automatic logic pol(input bit active);
        return active ? SYNC_ON : ~SYNC_ON;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic chk_a(input string tag, input int r, input int c, input bit en,
                         input bit hb, input bit vb, input bit hs, input bit vs);
        chk({tag, "_A_row"},    32'(row_a), 32'(r));
        chk({tag, "_A_col"},    32'(col_a), 32'(c));
        chk({tag, "_A_en_r"},   32'(en_a),  32'(en));
        chk({tag, "_A_hBlank"}, 32'(hb_a),  32'(hb));
        chk({tag, "_A_vBlank"}, 32'(vb_a),  32'(vb));
        chk({tag, "_A_Hsync"},  32'(hs_a),  32'(pol(hs)));
        chk({tag, "_A_Vsync"},  32'(vs_a),  32'(pol(vs)));
    endtask

    task automatic chk_b(input string tag, input int r, input int c, input bit en,
                         input bit hb, input bit vb, input bit hs, input bit vs);
        chk({tag, "_B_row"},    32'(row_b), 32'(r));
        chk({tag, "_B_col"},    32'(col_b), 32'(c));
        chk({tag, "_B_en_r"},   32'(en_b),  32'(en));
        chk({tag, "_B_hBlank"}, 32'(hb_b),  32'(hb));
        chk({tag, "_B_vBlank"}, 32'(vb_b),  32'(vb));
        chk({tag, "_B_Hsync"},  32'(hs_b),  32'(pol(hs)));
        chk({tag, "_B_Vsync"},  32'(vs_b),  32'(pol(vs)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired at cycle %0d", cur);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_hs_a, cnt_en_a, cnt_vs_b, cnt_en_b, cnt_hs_b;

        // ---------------- vector table (sorted by cycle) ----------------
        //  cyc   sel row col en hb vb hs vs
        add(   0, 0,  0,  0, 1, 0, 0, 0, 0);
        add(   0, 1,  0,  0, 1, 0, 0, 0, 0);
        add(   1, 0,  0,  0, 1, 0, 0, 0, 0);   // A holds between pixel enables
        add(   1, 1,  0,  1, 1, 0, 0, 0, 0);   // B advances every clock
        add(   2, 0,  0,  1, 1, 0, 0, 0, 0);
        add(   7, 1,  0,  7, 1, 0, 0, 0, 0);
        add(   8, 1,  0,  0, 0, 1, 0, 0, 0);
        add(  10, 1,  0,  0, 0, 1, 0, 1, 0);
        add(  12, 1,  0,  0, 0, 1, 0, 1, 0);
        add(  13, 1,  0,  0, 0, 1, 0, 0, 0);
        add(  15, 1,  1,  0, 1, 0, 0, 0, 0);
        add(  52, 1,  3,  7, 1, 0, 0, 0, 0);
        add(  89, 1,  0,  0, 0, 1, 0, 0, 0);
        add(  90, 1,  0,  0, 0, 0, 1, 0, 0);
        add( 104, 1,  0,  0, 0, 1, 1, 0, 0);
        add( 105, 1,  0,  0, 0, 0, 1, 0, 1);
        add( 134, 1,  0,  0, 0, 1, 1, 0, 1);
        add( 135, 1,  0,  0, 0, 0, 1, 0, 0);
        add( 149, 1,  0,  0, 0, 1, 1, 0, 0);
        add( 150, 1,  0,  0, 1, 0, 0, 0, 0);   // B frame wrap
        add( 151, 1,  0,  1, 1, 0, 0, 0, 0);
        add( 165, 1,  1,  0, 1, 0, 0, 0, 0);
        add(1278, 0,  0,639, 1, 0, 0, 0, 0);
        add(1279, 0,  0,639, 1, 0, 0, 0, 0);
        add(1280, 0,  0,  0, 0, 1, 0, 0, 0);
        add(1311, 0,  0,  0, 0, 1, 0, 0, 0);
        add(1312, 0,  0,  0, 0, 1, 0, 1, 0);
        add(1503, 0,  0,  0, 0, 1, 0, 1, 0);
        add(1504, 0,  0,  0, 0, 1, 0, 0, 0);
        add(1599, 0,  0,  0, 0, 1, 0, 0, 0);
        add(1600, 0,  1,  0, 1, 0, 0, 0, 0);   // A next line
        add(1602, 0,  1,  1, 1, 0, 0, 0, 0);
        add(2880, 0,  0,  0, 0, 1, 0, 0, 0);
        add(2912, 0,  0,  0, 0, 1, 0, 1, 0);

        // ---------------- reset and release ----------------
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        cur   = 0;

        foreach (vecs[i]) begin
            while (cur < vecs[i].cyc) tick();
            if (vecs[i].sel)
                chk_b($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].en,
                      vecs[i].hb, vecs[i].vb, vecs[i].hs, vecs[i].vs);
            else
                chk_a($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].en,
                      vecs[i].hb, vecs[i].vb, vecs[i].hs, vecs[i].vs);
        end

        // ---------------- one full period of each raster ----------------
        cnt_hs_a = 0; cnt_en_a = 0; cnt_vs_b = 0; cnt_en_b = 0; cnt_hs_b = 0;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (hs_a == SYNC_ON) cnt_hs_a++;
            if (en_a) cnt_en_a++;
            if (i < 150) begin
                if (vs_b == SYNC_ON) cnt_vs_b++;
                if (hs_b == SYNC_ON) cnt_hs_b++;
                if (en_b) cnt_en_b++;
            end
        end
        chk("A_hsync_width_clocks", 32'(cnt_hs_a), 32'd192);
        chk("A_visible_clocks_line", 32'(cnt_en_a), 32'd1280);
        chk("B_vsync_width_clocks", 32'(cnt_vs_b), 32'd30);
        chk("B_hsync_clocks_frame", 32'(cnt_hs_b), 32'd30);
        chk("B_visible_clocks_frame", 32'(cnt_en_b), 32'd48);

        // ---------------- mid-frame reset, instance B ----------------
        // Stop where B sits at vcnt=7, hcnt=11: both syncs active.
        while ((cur % 150) != 116) tick();
        chk_b("preB", 0, 0, 0, 1, 1, 1, 1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk_b("rstB", 0, 0, 1, 0, 0, 0, 0);
        tick();
        chk_b("rstB+1", 0, 1, 1, 0, 0, 0, 0);

        // ---------------- mid-line reset, instance A ----------------
        // Stop where A sits at hcnt=700 (inside Hsync), divider at 0.
        while ((cur % 1600) != 1400) tick();
        chk("preA_Hsync", 32'(hs_a), 32'(pol(1'b1)));
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk_a("rstA", 0, 0, 1, 0, 0, 0, 0);
        tick();
        chk("rstA+1_col", 32'(col_a), 32'd0);   // divider restarted too
        tick();
        chk("rstA+2_col", 32'(col_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
